// File: rtl/cfg_loader_pkg.sv
// Shared types and CRC constants for the column configuration loader.
package cfg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SET   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One serial CRC-16-CCITT step: MSB-out feedback XORed with the incoming bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ din) == 1'b1) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator; clr reloads the seed, en folds in one bit.
module cfg_crc16_serial
  import cfg_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_din,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_crc <= CRC_INIT;
    end else if (i_clr) begin
      r_crc <= CRC_INIT;
    end else if (i_en) begin
      r_crc <= crc16_step(r_crc, i_din);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams host config words LSB-first into a CLB column chain, then latches and
// re-enables the fabric. Define CFG_CRC_EN to require a CRC-16 trailer word.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              shift_out,
  output logic              shift_en,
  output logic              set_out,
  output logic              fabric_cen,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WIDX_W = $clog2(WORD_W + 1);

  state_e              r_state;
  logic [WORD_W-1:0]   r_hold;
  logic [CNT_W-1:0]    r_bits_left;
  logic [WIDX_W-1:0]   r_word_bits;
  logic                r_cfg_ready;
  logic                r_shift_out;
  logic                r_shift_en;
  logic                r_set_out;
  logic                r_fabric_cen;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic w_accept;
  logic w_start;
  logic w_shift;
  logic w_crc_ok;

  // r_cfg_ready is only ever set while in SHIFT, so this is the SHIFT handshake.
  assign w_accept = r_cfg_ready & cfg_valid;
  assign w_start  = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_shift  = (r_state == SHIFT) & (r_word_bits != '0);

`ifdef CFG_CRC_EN
  localparam logic        TRAILER = 1'b1;
  localparam int unsigned CMP_W   = (WORD_W < 16) ? WORD_W : 16;

  logic [15:0] w_crc;

  cfg_crc16_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_start),
    .i_en  (w_shift),
    .i_din (r_hold[0]),
    .o_crc (w_crc)
  );

  assign w_crc_ok = (cfg_data[CMP_W-1:0] == w_crc[CMP_W-1:0]);
`else
  localparam logic TRAILER = 1'b0;

  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_bits_left  <= '0;
      r_word_bits  <= '0;
      r_cfg_ready  <= 1'b0;
      r_shift_out  <= 1'b0;
      r_shift_en   <= 1'b0;
      r_set_out    <= 1'b0;
      r_fabric_cen <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_shift_en <= 1'b0;
      r_set_out  <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state      <= SHIFT;
            r_bits_left  <= CNT_W'(CHAIN_LEN);
            r_word_bits  <= '0;
            r_cfg_ready  <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_fabric_cen <= 1'b0;
            r_error      <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_accept && (r_bits_left == '0)) begin
            // Trailer word: only reachable when the CRC check is built in.
            r_cfg_ready <= 1'b0;
            if (w_crc_ok) begin
              r_state   <= SET;
              r_set_out <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_error <= 1'b1;
            end
          end else if (w_accept) begin
            r_hold      <= cfg_data;
            r_word_bits <= WIDX_W'(WORD_W);
            r_cfg_ready <= 1'b0;
          end else if (w_shift) begin
            r_shift_out <= r_hold[0];
            r_shift_en  <= 1'b1;
            r_hold      <= r_hold >> 1;
            r_bits_left <= r_bits_left - CNT_W'(1);
            if (r_bits_left == CNT_W'(1)) begin
              // Chain full: drop any leftover bits of a truncated final word.
              r_word_bits <= '0;
              r_cfg_ready <= TRAILER;
            end else begin
              r_word_bits <= r_word_bits - WIDX_W'(1);
              r_cfg_ready <= (r_word_bits == WIDX_W'(1));
            end
          end else if ((r_bits_left == '0) && !TRAILER) begin
            r_state     <= SET;
            r_set_out   <= 1'b1;
            r_cfg_ready <= 1'b0;
          end
        end
        SET: begin
          r_state      <= DONE;
          r_done       <= 1'b1;
          r_fabric_cen <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign shift_out  = r_shift_out;
  assign shift_en   = r_shift_en;
  assign set_out    = r_set_out;
  assign fabric_cen = r_fabric_cen;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: a 16-bit and a 12-bit chain with 8-bit words.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start16, valid16, start12, valid12;
  logic [7:0] data16, data12;
  logic       ready16, sout16, sen16, set16, cen16, busy16, done16, err16;
  logic       ready12, sout12, sen12, set12, cen12, busy12, done12, err12;

  cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .cfg_data(data16), .cfg_valid(valid16),
    .cfg_ready(ready16), .shift_out(sout16), .shift_en(sen16), .set_out(set16),
    .fabric_cen(cen16), .busy(busy16), .done(done16), .error(err16)
  );

  cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) u_dut12 (
    .clk(clk), .rst(rst), .start(start12), .cfg_data(data12), .cfg_valid(valid12),
    .cfg_ready(ready12), .shift_out(sout12), .shift_en(sen12), .set_out(set12),
    .fabric_cen(cen12), .busy(busy12), .done(done12), .error(err12)
  );

  int nchk  = 0;
  int npass = 0;

  logic [31:0] g_bits;
  logic [31:0] g_enpat;
  int          g_nshift, g_setidx, g_nset, g_doneidx, g_erridx, g_ready_after;
  logic        g_cen_s, g_done_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // {ready, shift_out, shift_en, set_out, fabric_cen, busy, done, error}
  function automatic logic [7:0] outs(input bit sel);
    if (sel) outs = {ready12, sout12, sen12, set12, cen12, busy12, done12, err12};
    else     outs = {ready16, sout16, sen16, set16, cen16, busy16, done16, err16};
  endfunction

`ifdef CFG_CRC_EN
  function automatic logic [15:0] crc_model(input logic [31:0] bits, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`endif

  task automatic drive(input bit sel, input logic s, input logic v, input logic [7:0] d);
    if (sel) begin
      start12 = s; valid12 = v; data12 = d;
    end else begin
      start16 = s; valid16 = v; data16 = d;
    end
  endtask

  // Full load: start pulse, words offered whenever ready, optional stall before
  // word 1, optional stray start pulse, optional corrupted CRC trailer.
  task automatic do_load(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                         input int stall, input int poke, input bit bad);
    logic [7:0] words [3];
    logic [7:0] o, d;
    logic       rdy, v, acc;
    int         nw, idx, scnt, it, len;
    len      = sel ? 12 : 16;
    words[0] = w0;
    words[1] = w1;
    words[2] = {7'h00, bad};
    nw       = 2;
`ifdef CFG_CRC_EN
    words[2] = 8'(crc_model({16'h0000, w1, w0}, len)) ^ {7'h00, bad};
    nw       = 3;
`endif
    g_bits = '0; g_enpat = '0; g_nshift = 0; g_setidx = -1; g_nset = 0;
    g_doneidx = -1; g_erridx = -1; g_ready_after = 0;
    drive(sel, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    o = outs(sel);
    g_cen_s  = o[3];
    g_done_s = o[1];
    drive(sel, 1'b0, 1'b0, 8'h00);
    idx = 0; scnt = 0; it = 0;
    while (g_doneidx < 0 && g_erridx < 0 && it < 60 + len) begin
      o   = outs(sel);
      rdy = o[7];
      v   = (idx < nw);
      if (idx == 1 && rdy && scnt < stall) begin
        v = 1'b0;
        scnt++;
      end
      acc = rdy && v;
      d   = (v && idx < 3) ? words[idx] : 8'h00;
      drive(sel, (it + 1 == poke), v, d);
      @(negedge clk);
      it++;
      if (acc) idx++;
      o = outs(sel);
      if (o[5]) begin
        if (g_nshift < 32) g_bits[g_nshift] = o[6];
        g_nshift++;
        if (it <= 32) g_enpat[it-1] = 1'b1;
      end
      if (o[4]) begin
        g_nset++;
        g_setidx = it;
      end
      if (o[1]) g_doneidx = it;
      if (o[0]) g_erridx = it;
      if (o[7] && idx >= nw) g_ready_after++;
    end
    drive(sel, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int cnt, it, nset;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    check("reset_outs16", 32'(outs(1'b0)), 32'h0);
    check("reset_outs12", 32'(outs(1'b1)), 32'h0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'hA5);
    @(negedge clk);
    check("idle_valid_ignored", 32'(outs(1'b0)), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    // Basic 16-bit load, valid always high.
    do_load(1'b0, 8'hA5, 8'h3C, 0, 0, 1'b0);
    check("a_start_cen", 32'(g_cen_s), 32'h0);
    check("a_bits", g_bits, 32'h0000_3CA5);
    check("a_nshift", 32'(g_nshift), 32'd16);
    check("a_en_pattern", g_enpat, 32'h0003_FDFE);
    check("a_set_idx", 32'(g_setidx), 32'd19);
    check("a_nset", 32'(g_nset), 32'd1);
    check("a_done_idx", 32'(g_doneidx), 32'd20);
    check("a_done_cen_busy_done", 32'({cen16, busy16, done16}), 32'b101);

    // Reload from DONE with a 5-cycle stall before the second word.
    do_load(1'b0, 8'hA5, 8'h3C, 5, 0, 1'b0);
    check("b_reload_cen_done", 32'({g_cen_s, g_done_s}), 32'b00);
    check("b_bits", g_bits, 32'h0000_3CA5);
    check("b_nshift", 32'(g_nshift), 32'd16);
    check("b_done_idx", 32'(g_doneidx), 32'd25);
    check("b_nset", 32'(g_nset), 32'd1);

    // Stray start mid-shift must be ignored.
    do_load(1'b0, 8'hA5, 8'h3C, 0, 5, 1'b0);
    check("e_bits", g_bits, 32'h0000_3CA5);
    check("e_nshift", 32'(g_nshift), 32'd16);
    check("e_done_idx", 32'(g_doneidx), 32'd20);

    // 12-bit chain: second word truncated.
    do_load(1'b1, 8'hFF, 8'h0F, 0, 0, 1'b0);
    check("c_bits", g_bits, 32'h0000_0FFF);
    check("c_nshift", 32'(g_nshift), 32'd12);
    check("c_ready_after", 32'(g_ready_after), 32'd0);
    check("c_set_idx", 32'(g_setidx), 32'd15);
    check("c_done_idx", 32'(g_doneidx), 32'd16);

    // Reset after 7 bits of a load.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'hA5);
    cnt = 0; it = 0;
    while (cnt < 7 && it < 40) begin
      @(negedge clk);
      it++;
      if (sen16) cnt++;
    end
    check("d_bits_before_reset", 32'(cnt), 32'd7);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("d_reset_outs16", 32'(outs(1'b0)), 32'h0);
    rst  = 1'b1;
    nset = 0;
    repeat (30) begin
      @(negedge clk);
      if (set16) nset++;
    end
    check("d_no_set_pulse", 32'(nset), 32'd0);
    check("d_idle_outs16", 32'(outs(1'b0)), 32'h0);
    do_load(1'b0, 8'h5A, 8'hC3, 0, 0, 1'b0);
    check("d_reload_bits", g_bits, 32'h0000_C35A);
    check("d_reload_done_idx", 32'(g_doneidx), 32'd20);

`ifdef CFG_CRC_EN
    // Corrupted trailer: no latch, sticky error, fabric stays disabled.
    do_load(1'b0, 8'hA5, 8'h3C, 0, 0, 1'b1);
    check("f_bad_nset", 32'(g_nset), 32'd0);
    check("f_bad_err_seen", 32'(g_erridx >= 0), 32'd1);
    repeat (3) @(negedge clk);
    check("f_bad_cen_busy_done_err", 32'({cen16, busy16, done16, err16}), 32'b0001);
    do_load(1'b0, 8'hA5, 8'h3C, 0, 0, 1'b0);
    check("f_good_nset", 32'(g_nset), 32'd1);
    check("f_good_done_err", 32'({done16, err16}), 32'b10);
`endif

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
